parity_rx: RTL and testbench

PARITY_RX -- requirements
Module: parity_rx

---
 rtl/parity_rx.sv | 169 ++++++++++++++++
 tb/tb_parity_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/parity_rx.sv
// rtl/parity_rx.sv - serial frame receiver with parity and stop-bit checking
module parity_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic          POL      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              rx_m, rx_s;
  logic [DATA_W-1:0] shreg;
  logic              acc;
  logic              mismatch;
  logic              bit_tick;
  logic              take_bit;
  logic              take_par;
  logic              frame_ok;
  logic              frame_bad;

  // Synchronizer resets to the idle line level so release never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign bit_tick = (cnt_q == CNT_FULL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    take_bit  = 1'b0;
    take_par  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Mid start bit: a high line here was only a glitch
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d    = '0;
          take_bit = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          cnt_d    = '0;
          take_par = 1'b1;
          state_d  = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (rx_s) begin
            frame_ok = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      acc        <= 1'b0;
      mismatch   <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        acc <= 1'b0;
      end else if (take_bit) begin
        shreg[idx_q] <= rx_s;
        acc          <= acc ^ rx_s;
      end
      if (take_par) mismatch <= rx_s ^ acc ^ POL;
      if (frame_ok) data_out <= shreg;
      valid      <= frame_ok;
      parity_err <= frame_ok & mismatch;
      frame_err  <= frame_bad;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_parity_rx.sv
// tb/tb_parity_rx.sv - scoreboard bench for parity_rx with randomized frames
module tb_parity_rx;
  localparam int CPB = 4;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DW-1:0] data_out;
  logic          valid, parity_err, frame_err, busy;

  parity_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out),
    .valid(valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit            ferr;
    logic [DW-1:0] data;
    bit            perr;
    int            t0;
  } exp_t;

  exp_t          q[$];
  exp_t          me;
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] last_good = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per observed frame event
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (valid || frame_err) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b with no frame pending", valid, frame_err);
        end else begin
          me = q.pop_front();
          check("frame_err", {31'd0, frame_err}, {31'd0, me.ferr});
          check("valid", {31'd0, valid}, {31'd0, !me.ferr});
          check("data_out", {24'd0, data_out}, {24'd0, me.data});
          if (!me.ferr) begin
            check("parity_err", {31'd0, parity_err}, {31'd0, me.perr});
            tests++;
            if (cyc - me.t0 < 43 || cyc - me.t0 > 46) begin
              fails++;
              $display("FAIL latency: got %0d cycles, expected 43..46", cyc - me.t0);
            end
          end
        end
      end else if (parity_err) begin
        tests++;
        fails++;
        $display("FAIL stray_parity_err: got 1, expected 0 without valid");
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input bit pflip, input bit stopb);
    exp_t e;
    e.ferr = !stopb;
    e.perr = pflip;
    e.data = stopb ? d : last_good;
    e.t0   = cyc;
    if (stopb) last_good = d;
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit((^d) ^ pflip);
    drive_bit(stopb);
  endtask

  initial begin
    bit            ok;
    int            n;
    logic [DW-1:0] d;
    bit            sb;

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      rx = 1'($urandom);
      @(negedge clk);
      check("reset_outputs", {19'd0, valid, parity_err, frame_err, busy, data_out}, 32'd0);
    end
    rx = 1'b1;
    rst_n = 1'b1;
    idle_bits(3);

    send_frame(8'hA5, 1'b0, 1'b1);
    idle_bits(2);
    send_frame(8'hA5, 1'b1, 1'b1);
    idle_bits(2);

    send_frame(8'h3C, 1'b0, 1'b0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!busy) ok = 1'b0;
    end
    check("busy_held_low_line", {31'd0, ok}, 32'd1);
    rx = 1'b1;
    n = 0;
    while (busy && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("busy_release", {31'd0, busy}, 32'd0);
    idle_bits(1);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (CPB + 3) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    idle_bits(1);

    d = 8'hA5;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(d[i]);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {20'd0, valid, parity_err, frame_err, busy, data_out}, 32'd0);
    last_good = '0;
    @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle_bits(1);

    for (int k = 0; k < 40; k++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      send_frame(d, $urandom_range(0, 3) == 0, sb);
      if (sb) idle_bits($urandom_range(0, 2));
      else idle_bits($urandom_range(1, 2));
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
